// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for mem_arbiter: one instance per requester port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between two requesters,
// one access in flight at a time; byte addresses are converted to word addresses.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              win_q;
  logic              is_write_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              gnt_valid;
  logic              gnt_port;
  logic              unused_addr_lsb;

  // On a tie the port that did not win last time is chosen.
  assign gnt_valid = m0.req | m1.req;
  assign gnt_port  = (m0.req & m1.req) ? ~last_grant_q : m1.req;

  // Byte-lane select bit is meaningless for a word memory.
  assign unused_addr_lsb = m0.addr[0] ^ m1.addr[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = is_write_q ? DONE : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            win_q        <= gnt_port;
            last_grant_q <= gnt_port;
            is_write_q   <= gnt_port ? m1.we : m0.we;
            mem_we       <= gnt_port ? m1.we : m0.we;
            mem_addr     <= gnt_port ? m1.addr[ADDR_W-1:1] : m0.addr[ADDR_W-1:1];
            mem_wdata    <= gnt_port ? m1.wdata : m0.wdata;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          cnt_q  <= CNT_W'(MEM_LAT);
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (win_q) rdata1_q <= mem_rdata;
            else       rdata0_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0.ack   = (state_q == DONE) && !win_q;
  assign m1.ack   = (state_q == DONE) &&  win_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance (a*) and MEM_LAT=3 instance (b*),
// each backed by a behavioural word memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) a0 ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) a1 ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b1 ();

  logic        a_mem_we, b_mem_we;
  logic [6:0]  a_mem_addr, b_mem_addr;
  logic [15:0] a_mem_wdata, b_mem_wdata;
  logic [15:0] a_mem_rdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(b0), .m1(b1),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Behavioural memories: unwritten words read as 16'hA000 | word_address.
  logic [15:0] mem_a [128];
  bit          wr_a  [128];
  logic [15:0] mem_b [128];
  bit          wr_b  [128];
  logic [15:0] rd_b1, rd_b2;

  always @(posedge clk) begin
    if (a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
      wr_a[a_mem_addr]  <= 1'b1;
    end
    a_mem_rdata <= wr_a[a_mem_addr] ? mem_a[a_mem_addr] : (16'hA000 | {9'd0, a_mem_addr});
  end

  always @(posedge clk) begin
    if (b_mem_we) begin
      mem_b[b_mem_addr] <= b_mem_wdata;
      wr_b[b_mem_addr]  <= 1'b1;
    end
    rd_b1       <= wr_b[b_mem_addr] ? mem_b[b_mem_addr] : (16'hA000 | {9'd0, b_mem_addr});
    rd_b2       <= rd_b1;
    b_mem_rdata <= rd_b2;
  end

  function automatic logic get_ack(input bit d, input bit p);
    return d ? (p ? b1.ack : b0.ack) : (p ? a1.ack : a0.ack);
  endfunction

  function automatic logic [15:0] get_rdata(input bit d, input bit p);
    return d ? (p ? b1.rdata : b0.rdata) : (p ? a1.rdata : a0.rdata);
  endfunction

  function automatic logic get_mem_we(input bit d);
    return d ? b_mem_we : a_mem_we;
  endfunction

  function automatic logic [6:0] get_mem_addr(input bit d);
    return d ? b_mem_addr : a_mem_addr;
  endfunction

  task automatic set_port(input bit d, input bit p, input logic req, input logic we,
                          input logic [7:0] addr, input logic [15:0] wdata);
    case ({d, p})
      2'b00: begin a0.req = req; a0.we = we; a0.addr = addr; a0.wdata = wdata; end
      2'b01: begin a1.req = req; a1.we = we; a1.addr = addr; a1.wdata = wdata; end
      2'b10: begin b0.req = req; b0.we = we; b0.addr = addr; b0.wdata = wdata; end
      default: begin b1.req = req; b1.we = we; b1.addr = addr; b1.wdata = wdata; end
    endcase
  endtask

  // Single access; call #1 after a posedge with the DUT idle. lat=-1 means no ack seen.
  task automatic access(input bit d, input bit p, input bit we, input logic [7:0] addr,
                        input logic [15:0] wdata, output int lat, output logic [15:0] rd,
                        output int we_cnt, output logic [6:0] iss_addr);
    lat = -1; rd = '0; we_cnt = 0; iss_addr = '0;
    set_port(d, p, 1'b1, we, addr, wdata);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (get_mem_we(d)) we_cnt++;
      if (n == 1) iss_addr = get_mem_addr(d);
      if (get_ack(d, p)) begin lat = n; rd = get_rdata(d, p); end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    set_port(d, p, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int we_seen;
    int ack_seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata, a0.ack, a1.ack, a0.rdata, a1.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got we=%b addr=%h wd=%h ack=%b%b rd0=%h rd1=%h want all 0",
               a_mem_we, a_mem_addr, a_mem_wdata, a0.ack, a1.ack, a0.rdata, a1.rdata);
    end
    n_cmp++;
    if ({b_mem_we, b_mem_addr, b_mem_wdata, b0.ack, b1.ack, b0.rdata, b1.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got we=%b addr=%h wd=%h ack=%b%b want all 0",
               b_mem_we, b_mem_addr, b_mem_wdata, b0.ack, b1.ack);
    end
    rst_n = 1'b1;
    we_seen = 0; ack_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (a_mem_we || b_mem_we) we_seen++;
      if (a0.ack || a1.ack || b0.ack || b1.ack) ack_seen++;
    end
    n_cmp++;
    if (we_seen !== 0) begin
      n_fail++; $display("FAIL idle_mem_we: got %0d cycles high want 0", we_seen);
    end
    n_cmp++;
    if (ack_seen !== 0) begin
      n_fail++; $display("FAIL idle_ack: got %0d ack cycles want 0", ack_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat, wec; logic [15:0] rd; logic [6:0] ia;
    access(1'b0, 1'b0, 1'b1, 8'h06, 16'hF104, lat, rd, wec, ia);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
    n_cmp++;
    if (wec !== 1) begin n_fail++; $display("FAIL wr_mem_we_cycles: got %0d want 1", wec); end
    n_cmp++;
    if (ia !== 7'h03) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 03", ia); end
    n_cmp++;
    if (mem_a[3] !== 16'hF104) begin
      n_fail++; $display("FAIL wr_committed: got %h want f104", mem_a[3]);
    end
    access(1'b0, 1'b0, 1'b0, 8'h06, 16'h0000, lat, rd, wec, ia);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++;
    if (rd !== 16'hF104) begin n_fail++; $display("FAIL rd_data: got %h want f104", rd); end
    n_cmp++;
    if (wec !== 0) begin n_fail++; $display("FAIL rd_mem_we_cycles: got %0d want 0", wec); end
    n_cmp++;
    if (ia !== 7'h03) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 03", ia); end
  endtask

  task automatic test_odd_addr();
    int lat, wec; logic [15:0] rd; logic [6:0] ia;
    access(1'b0, 1'b0, 1'b0, 8'h07, 16'h0000, lat, rd, wec, ia);
    n_cmp++;
    if (ia !== 7'h03) begin n_fail++; $display("FAIL odd_mem_addr: got %h want 03", ia); end
    n_cmp++;
    if (rd !== 16'hF104) begin n_fail++; $display("FAIL odd_rd_data: got %h want f104", rd); end
    // A write must leave the port's read data register untouched.
    access(1'b0, 1'b0, 1'b1, 8'h40, 16'h0BEE, lat, rd, wec, ia);
    n_cmp++;
    if (a0.rdata !== 16'hF104) begin
      n_fail++; $display("FAIL rdata_hold_after_write: got %h want f104", a0.rdata);
    end
  endtask

  task automatic test_collision();
    int t0, t1, both; logic [15:0] r0;
    t0 = -1; t1 = -1; both = 0; r0 = '0;
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 16'h5312);
    set_port(1'b0, 1'b0, 1'b1, 1'b0, 8'h08, 16'h0000);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (a0.ack && a1.ack) both++;
      if (a0.ack && t0 < 0) begin t0 = n; r0 = a0.rdata; end
      if (a1.ack && t1 < 0) t1 = n;
      @(posedge clk); #1;
      if (t0 == n) a0.req = 1'b0;
      if (t1 == n) a1.req = 1'b0;
    end
    a0.req = 1'b0; a1.req = 1'b0;
    n_cmp++;
    if (t1 !== 2) begin n_fail++; $display("FAIL coll_p1_ack_cycle: got %0d want 2", t1); end
    n_cmp++;
    if (t0 !== 6) begin n_fail++; $display("FAIL coll_p0_ack_cycle: got %0d want 6", t0); end
    n_cmp++;
    if (r0 !== 16'h5312) begin n_fail++; $display("FAIL coll_p0_rdata: got %h want 5312", r0); end
    n_cmp++;
    if (both !== 0) begin n_fail++; $display("FAIL coll_dual_ack: got %0d want 0", both); end
  endtask

  task automatic test_arbitration();
    logic e0, e1;
    pulse_reset();
    set_port(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    set_port(1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 16'h0000);
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      e0 = (n == 3) || (n == 11);
      e1 = (n == 7) || (n == 15);
      n_cmp++;
      if (a0.ack !== e0 || a1.ack !== e1) begin
        n_fail++;
        $display("FAIL rr_ack_cycle%0d: got ack0=%b ack1=%b want ack0=%b ack1=%b",
                 n, a0.ack, a1.ack, e0, e1);
      end
      if (e0) begin
        n_cmp++;
        if (a0.rdata !== 16'hA010) begin
          n_fail++; $display("FAIL rr_p0_rdata: got %h want a010", a0.rdata);
        end
      end
      if (e1) begin
        n_cmp++;
        if (a1.rdata !== 16'hA018) begin
          n_fail++; $display("FAIL rr_p1_rdata: got %h want a018", a1.rdata);
        end
      end
      @(posedge clk); #1;
      if (n == 15) begin a0.req = 1'b0; a1.req = 1'b0; end
    end
  endtask

  task automatic test_reset_mid();
    int lat, wec, acks; logic [15:0] rd; logic [6:0] ia;
    // Reset during the WAIT cycle of a read.
    set_port(1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++;
    if (a0.ack !== 1'b0 || a0.rdata !== 16'h0000 || a_mem_addr !== 7'h00) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got ack=%b rd=%h addr=%h want 0 0000 00",
               a0.ack, a0.rdata, a_mem_addr);
    end
    a0.req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (a0.ack || a1.ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_fail++; $display("FAIL rst_wait_no_ack: got %0d want 0", acks); end
    @(posedge clk); #1;
    // Reset during the ISSUE cycle of a write.
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 16'h1111);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_mem_we !== 1'b1) begin n_fail++; $display("FAIL issue_we_before_rst: got %b want 1", a_mem_we); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (a_mem_we !== 1'b0 || a1.ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_issue_async: got we=%b ack=%b want 0 0", a_mem_we, a1.ack);
    end
    a1.req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b0, 8'h06, 16'h0000, lat, rd, wec, ia);
    n_cmp++;
    if (rd !== 16'hF104) begin n_fail++; $display("FAIL rst_write_not_committed: got %h want f104", rd); end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL post_rst_latency: got %0d want 3", lat); end
  endtask

  task automatic test_latency3();
    int lat, wec; logic [15:0] rd; logic [6:0] ia;
    access(1'b1, 1'b0, 1'b1, 8'h06, 16'hF104, lat, rd, wec, ia);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL lat3_wr_latency: got %0d want 2", lat); end
    access(1'b1, 1'b0, 1'b0, 8'h06, 16'h0000, lat, rd, wec, ia);
    n_cmp++;
    if (lat !== 5) begin n_fail++; $display("FAIL lat3_rd_latency: got %0d want 5", lat); end
    n_cmp++;
    if (rd !== 16'hF104) begin n_fail++; $display("FAIL lat3_rd_data: got %h want f104", rd); end
    n_cmp++;
    if (ia !== 7'h03) begin n_fail++; $display("FAIL lat3_mem_addr: got %h want 03", ia); end
  endtask

  initial begin
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    test_reset();
    test_write_read();
    test_odd_addr();
    test_collision();
    test_arbitration();
    test_reset_mid();
    test_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
